// File: rtl/mem_dma.sv
// ---------------------------------------------------------------------------
// mem_dma -- word-copy DMA engine on the native picorv32 memory bus.
//
// Copies LEN 32-bit words from SRC to DST using a bus initiator port and
// optionally raises a level interrupt when the copy completes.
//
// Optional feature macro: MEM_DMA_FILL_EN
//   When defined, CTRL bit4 FILL selects fill mode. In fill mode the SRC
//   register value is written to every destination word and no reads are
//   issued. When undefined, bit4 reads 0 and fill logic is absent.
//
// Parameters:
//   LEN_BITS   width of the word-count register (max 2^LEN_BITS-1 words)
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cfg_valid/cfg_ready   config responder handshake (ready is a 1-cycle pulse)
//   cfg_wstrb             config byte strobes, 0 = read
//   cfg_addr              config address, only [3:2] decoded
//   cfg_wdata/cfg_rdata   config write / read data (rdata 0 unless ready)
//   m_valid/m_ready       initiator request / target completion
//   m_addr                word address of current access
//   m_wdata/m_wstrb       write data / strobes (4'hF write, 4'h0 read)
//   m_rdata               read data from target
//   irq                   level interrupt = DONE && IRQ_EN (registered)
//
// Register map (cfg_addr[3:2]):
//   0 SRC   1 DST   2 LEN   3 CTRL/STAT {FILL, IRQ_EN, DONE, BUSY, START}
// ---------------------------------------------------------------------------
module mem_dma #(
    parameter int LEN_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [3:0]  cfg_wstrb,
    input  logic [31:0] cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    output logic        irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    // Per-byte merge of new data into an existing 32-bit value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Programmed registers
    logic [31:0]         src_r;
    logic [31:0]         dst_r;
    logic [LEN_BITS-1:0] len_r;
    logic                done_r;
    logic                irq_en_r;
    logic                irq_r;

    // Engine working state
    logic [1:0]          state_r;
    logic [31:0]         src_ptr_r;
    logic [31:0]         dst_ptr_r;
    logic [LEN_BITS-1:0] count_r;
    logic [31:0]         buf_r;
    logic                fill_mode_r;

    // Registered bus outputs
    logic                cfg_ready_r;
    logic [31:0]         cfg_rdata_r;
    logic                m_valid_r;
    logic [31:0]         m_addr_r;
    logic [31:0]         m_wdata_r;
    logic [3:0]          m_wstrb_r;

    // Decoded strobes
    logic                busy_s;
    logic                cfg_acc_s;
    logic                cfg_wr_s;
    logic                ctrl_wr_s;
    logic                start_s;
    logic                done_clr_s;
    logic                last_done_s;
    logic                fill_s;
    logic                start_fill_s;
    logic [31:0]         rdata_s;

    // Only cfg_addr[3:2] is decoded.
    logic unused_addr_s;
    assign unused_addr_s = &{1'b0, cfg_addr[31:4], cfg_addr[1:0]};

    assign busy_s      = (state_r != ST_IDLE);
    // A new access is accepted only when no response is pending, giving the
    // one-cycle ready pulse even if cfg_valid is held.
    assign cfg_acc_s   = cfg_valid && !cfg_ready_r;
    assign cfg_wr_s    = cfg_acc_s && (cfg_wstrb != 4'h0);
    assign ctrl_wr_s   = cfg_wr_s && (cfg_addr[3:2] == 2'd3) && cfg_wstrb[0];
    assign start_s     = ctrl_wr_s && cfg_wdata[0] && !busy_s;
    assign done_clr_s  = ctrl_wr_s && cfg_wdata[2];
    assign last_done_s = (state_r == ST_WR) && m_valid_r && m_ready &&
                         (count_r == LEN_BITS'(1));

`ifdef MEM_DMA_FILL_EN
    logic fill_r;

    // FILL control bit, read/write through CTRL byte 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            fill_r <= cfg_wdata[4];
        end else begin
            fill_r <= fill_r;
        end
    end

    assign fill_s       = fill_r;
    // START and FILL may arrive in the same write; the written value counts.
    assign start_fill_s = cfg_wdata[4];
`else
    assign fill_s       = 1'b0;
    assign start_fill_s = 1'b0;
`endif

    // Config read mux; register values as they were before this access.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (cfg_addr[3:2])
            2'd0:    rdata_s = {src_r[31:2], 2'b00};
            2'd1:    rdata_s = {dst_r[31:2], 2'b00};
            2'd2:    rdata_s = 32'(len_r);
            2'd3:    rdata_s = {27'd0, fill_s, irq_en_r, done_r, busy_s, 1'b0};
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    // Config handshake: one-cycle ready pulse with read data, zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_ready_r <= 1'b0;
            cfg_rdata_r <= 32'h0000_0000;
        end else begin
            cfg_ready_r <= cfg_acc_s;
            cfg_rdata_r <= cfg_acc_s ? rdata_s : 32'h0000_0000;
        end
    end

    // SRC/DST/LEN byte-strobed writes, frozen while a transfer runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_r <= 32'h0000_0000;
            dst_r <= 32'h0000_0000;
            len_r <= '0;
        end else if (cfg_wr_s && !busy_s) begin
            case (cfg_addr[3:2])
                2'd0:    src_r <= merge_bytes(src_r, cfg_wdata, cfg_wstrb);
                2'd1:    dst_r <= merge_bytes(dst_r, cfg_wdata, cfg_wstrb);
                2'd2:    len_r <= LEN_BITS'(merge_bytes(32'(len_r), cfg_wdata, cfg_wstrb));
                default: src_r <= src_r;
            endcase
        end else begin
            src_r <= src_r;
        end
    end

    // IRQ_EN, DONE and the registered interrupt. Completion outranks a
    // DONE-clear in the same cycle; START clears DONE unless LEN=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_r <= 1'b0;
            done_r   <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                irq_en_r <= cfg_wdata[3];
            end else begin
                irq_en_r <= irq_en_r;
            end
            if (last_done_s || (start_s && (len_r == '0))) begin
                done_r <= 1'b1;
            end else if (start_s || done_clr_s) begin
                done_r <= 1'b0;
            end else begin
                done_r <= done_r;
            end
            irq_r <= done_r && irq_en_r;
        end
    end

    // Copy engine: each state spends one cycle with m_valid low, then holds
    // the request until m_ready, so m_valid drops the cycle after ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            src_ptr_r   <= 32'h0000_0000;
            dst_ptr_r   <= 32'h0000_0000;
            count_r     <= '0;
            buf_r       <= 32'h0000_0000;
            fill_mode_r <= 1'b0;
            m_valid_r   <= 1'b0;
            m_addr_r    <= 32'h0000_0000;
            m_wdata_r   <= 32'h0000_0000;
            m_wstrb_r   <= 4'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    m_valid_r <= 1'b0;
                    if (start_s && (len_r != '0)) begin
                        src_ptr_r   <= {src_r[31:2], 2'b00};
                        dst_ptr_r   <= {dst_r[31:2], 2'b00};
                        count_r     <= len_r;
                        fill_mode_r <= start_fill_s;
                        if (start_fill_s) begin
                            buf_r   <= src_r;
                            state_r <= ST_WR;
                        end else begin
                            state_r <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (!m_valid_r) begin
                        m_valid_r <= 1'b1;
                        m_addr_r  <= src_ptr_r;
                        m_wdata_r <= 32'h0000_0000;
                        m_wstrb_r <= 4'h0;
                    end else if (m_ready) begin
                        m_valid_r <= 1'b0;
                        buf_r     <= m_rdata;
                        src_ptr_r <= src_ptr_r + 32'd4;
                        state_r   <= ST_WR;
                    end else begin
                        m_valid_r <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (!m_valid_r) begin
                        m_valid_r <= 1'b1;
                        m_addr_r  <= dst_ptr_r;
                        m_wdata_r <= buf_r;
                        m_wstrb_r <= 4'hF;
                    end else if (m_ready) begin
                        m_valid_r <= 1'b0;
                        m_wstrb_r <= 4'h0;
                        dst_ptr_r <= dst_ptr_r + 32'd4;
                        count_r   <= count_r - LEN_BITS'(1);
                        if (count_r == LEN_BITS'(1)) begin
                            state_r <= ST_IDLE;
                        end else if (fill_mode_r) begin
                            state_r <= ST_WR;
                        end else begin
                            state_r <= ST_RD;
                        end
                    end else begin
                        m_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    m_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign cfg_rdata = cfg_rdata_r;
    assign m_valid   = m_valid_r;
    assign m_addr    = m_addr_r;
    assign m_wdata   = m_wdata_r;
    assign m_wstrb   = m_wstrb_r;
    assign irq       = irq_r;

endmodule

// File: tb/tb_mem_dma.sv
// ---------------------------------------------------------------------------
// tb_mem_dma -- self-checking bench for mem_dma.
// A bus target model answers initiator requests with m_rdata = addr ^
// 32'hA5A5A5A5 after a programmable number of wait cycles. Expected bus
// transactions are queued when a transfer is programmed and compared as the
// DUT issues them.
// ---------------------------------------------------------------------------
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_wstrb;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        irq;

    mem_dma #(.LEN_BITS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_wstrb (cfg_wstrb),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } xact_t;

    xact_t exp_q[$];
    xact_t exp_x;

    int chk_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    // Target model state
    int          tgt_wait     = 0;
    bit          tgt_stall_wr = 1'b0;
    bit          tgt_act      = 1'b0;
    int          tgt_cnt      = 0;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    int          n_rd      = 0;
    int          n_wr      = 0;
    int          n_req     = 0;
    int          first_cyc = -1;
    int          last_cyc  = -1;

    task automatic check32(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Bus target with wait states; compares each accepted request against
    // the scoreboard and checks request stability while waiting.
    always @(negedge clk) begin
        if (reset) begin
            m_ready = 1'b0;
            tgt_act = 1'b0;
            tgt_cnt = 0;
        end else if (m_ready) begin
            m_ready = 1'b0;
            tgt_act = 1'b0;
            tgt_cnt = 0;
            check32("valid_drop", {31'd0, m_valid}, 32'd0);
        end else if (m_valid) begin
            if (!tgt_act) begin
                tgt_act   = 1'b1;
                tgt_cnt   = 0;
                cap_addr  = m_addr;
                cap_wdata = m_wdata;
                cap_wstrb = m_wstrb;
                n_req++;
                if (first_cyc < 0) first_cyc = cyc;
            end else begin
                check32("stable_addr", m_addr, cap_addr);
                check32("stable_wdata", m_wdata, cap_wdata);
                check32("stable_wstrb", {28'd0, m_wstrb}, {28'd0, cap_wstrb});
            end
            if ((tgt_cnt >= tgt_wait) && !(tgt_stall_wr && (m_wstrb != 4'h0))) begin
                m_ready  = 1'b1;
                m_rdata  = m_addr ^ 32'hA5A5_A5A5;
                last_cyc = cyc;
                if (m_wstrb == 4'h0) n_rd++;
                else n_wr++;
                if (exp_q.size() == 0) begin
                    check32("sb_extra_addr", m_addr, 32'hFFFF_FFFF);
                end else begin
                    exp_x = exp_q.pop_front();
                    check32("sb_addr", m_addr, exp_x.addr);
                    check32("sb_wstrb", {28'd0, m_wstrb}, {28'd0, exp_x.wstrb});
                    if (exp_x.wstrb == 4'hF) check32("sb_wdata", m_wdata, exp_x.wdata);
                end
            end
            tgt_cnt++;
        end else begin
            tgt_act = 1'b0;
            tgt_cnt = 0;
        end
    end

    task automatic cfg_xfer(input logic [3:0] strb, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_wstrb = strb;
        cfg_addr  = addr;
        cfg_wdata = wdata;
        @(posedge clk);
        #1;
        rdata = cfg_rdata;
        check32("cfg_ready", {31'd0, cfg_ready}, 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_wstrb = 4'h0;
    endtask

    task automatic cfg_wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        cfg_xfer(4'hF, addr, data, d);
    endtask

    task automatic cfg_rd(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp);
        logic [31:0] d;
        cfg_xfer(4'h0, addr, 32'h0, d);
        check32(tag, d, exp);
    endtask

    task automatic wait_idle(input int max_polls);
        logic [31:0] st;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_polls; i++) begin
            cfg_xfer(4'h0, 32'hC, 32'h0, st);
            if (st[1] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check32("idle_timeout", {31'd0, ok}, 32'd1);
        @(negedge clk);
    endtask

    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst,
                             input int len);
        xact_t x;
        for (int i = 0; i < len; i++) begin
            x.addr  = src + 32'(4 * i);
            x.wstrb = 4'h0;
            x.wdata = 32'h0;
            exp_q.push_back(x);
            x.addr  = dst + 32'(4 * i);
            x.wstrb = 4'hF;
            x.wdata = (src + 32'(4 * i)) ^ 32'hA5A5_A5A5;
            exp_q.push_back(x);
        end
    endtask

    initial begin
        xact_t x;
        int req0;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_wstrb = 4'h0;
        cfg_addr  = 32'h0;
        cfg_wdata = 32'h0;
        m_ready   = 1'b0;
        m_rdata   = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check32("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check32("rst_irq", {31'd0, irq}, 32'd0);
        check32("rst_cfg_rdata", cfg_rdata, 32'd0);
        cfg_rd("rst_src", 32'h0, 32'h0);
        cfg_rd("rst_len", 32'h8, 32'h0);
        cfg_rd("rst_stat", 32'hC, 32'h0);

        // Zero-wait copy of 3 words with interrupt enabled
        tgt_wait = 0;
        cfg_wr(32'h0, 32'h100);
        cfg_wr(32'h4, 32'h200);
        cfg_wr(32'h8, 32'd3);
        push_copy(32'h100, 32'h200, 3);
        n_rd = 0; n_wr = 0; first_cyc = -1;
        cfg_wr(32'hC, 32'h9);
        wait_idle(50);
        check32("copy_nrd", n_rd, 32'd3);
        check32("copy_nwr", n_wr, 32'd3);
        check32("copy_q", exp_q.size(), 32'd0);
        check32("copy_span", last_cyc - first_cyc + 2, 32'd12);
        check32("copy_irq", {31'd0, irq}, 32'd1);
        cfg_rd("copy_stat", 32'hC, 32'hC);
        cfg_rd("copy_src_kept", 32'h0, 32'h100);
        cfg_wr(32'hC, 32'h4);
        @(negedge clk);
        check32("copy_irq_clr", {31'd0, irq}, 32'd0);

        // Three wait states per access
        tgt_wait = 3;
        cfg_wr(32'h0, 32'h300);
        cfg_wr(32'h4, 32'h400);
        cfg_wr(32'h8, 32'd2);
        push_copy(32'h300, 32'h400, 2);
        n_rd = 0; n_wr = 0; req0 = n_req;
        cfg_wr(32'hC, 32'h1);
        wait_idle(80);
        check32("ws_nrd", n_rd, 32'd2);
        check32("ws_nwr", n_wr, 32'd2);
        check32("ws_req", n_req - req0, 32'd4);
        check32("ws_q", exp_q.size(), 32'd0);
        cfg_rd("ws_stat", 32'hC, 32'h4);
        check32("ws_irq", {31'd0, irq}, 32'd0);
        cfg_wr(32'hC, 32'h4);

        // LEN=0 completes immediately without bus traffic
        tgt_wait = 0;
        cfg_wr(32'h8, 32'd0);
        req0 = n_req;
        cfg_wr(32'hC, 32'h9);
        repeat (5) @(negedge clk);
        check32("len0_noreq", n_req - req0, 32'd0);
        cfg_rd("len0_stat", 32'hC, 32'hC);
        check32("len0_irq", {31'd0, irq}, 32'd1);
        cfg_wr(32'hC, 32'h4);
        cfg_rd("len0_stat_clr", 32'hC, 32'h0);
        check32("len0_irq_clr", {31'd0, irq}, 32'd0);

        // Busy protection: DST write and second START ignored
        tgt_wait = 2;
        cfg_wr(32'h0, 32'h500);
        cfg_wr(32'h4, 32'h600);
        cfg_wr(32'h8, 32'd4);
        push_copy(32'h500, 32'h600, 4);
        n_rd = 0; n_wr = 0;
        cfg_wr(32'hC, 32'h1);
        cfg_rd("busy_stat", 32'hC, 32'h2);
        cfg_wr(32'h4, 32'h999);
        cfg_wr(32'hC, 32'h1);
        cfg_rd("busy_dst", 32'h4, 32'h600);
        wait_idle(100);
        check32("busy_nwr", n_wr, 32'd4);
        check32("busy_q", exp_q.size(), 32'd0);
        cfg_wr(32'hC, 32'h4);

        // Byte strobe on SRC: only byte 1 replaced
        begin
            logic [31:0] d;
            cfg_xfer(4'b0010, 32'h0, 32'h1234_AB78, d);
            cfg_rd("strb_src", 32'h0, 32'h0000_AB00);
        end

        // Pointer wrap past 0xFFFFFFFC
        tgt_wait = 0;
        cfg_wr(32'h0, 32'hFFFF_FFFC);
        cfg_wr(32'h4, 32'h800);
        cfg_wr(32'h8, 32'd2);
        push_copy(32'hFFFF_FFFC, 32'h800, 2);
        cfg_wr(32'hC, 32'h1);
        wait_idle(50);
        check32("wrap_q", exp_q.size(), 32'd0);
        cfg_wr(32'hC, 32'h4);

        // Reset while a write is pending
        tgt_stall_wr = 1'b1;
        cfg_wr(32'h0, 32'h900);
        cfg_wr(32'h4, 32'hA00);
        cfg_wr(32'h8, 32'd2);
        x.addr = 32'h900; x.wstrb = 4'h0; x.wdata = 32'h0;
        exp_q.push_back(x);
        cfg_wr(32'hC, 32'h1);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (m_valid && (m_wstrb == 4'hF)) begin
                    seen = 1'b1;
                    break;
                end
            end
            check32("rstmid_wr_seen", {31'd0, seen}, 32'd1);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check32("rstmid_m_valid", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tgt_stall_wr = 1'b0;
        req0 = n_req;
        repeat (6) @(negedge clk);
        check32("rstmid_noreq", n_req - req0, 32'd0);
        check32("rstmid_q", exp_q.size(), 32'd0);
        cfg_rd("rstmid_stat", 32'hC, 32'h0);
        cfg_rd("rstmid_src", 32'h0, 32'h0);

`ifdef MEM_DMA_FILL_EN
        // Fill mode: SRC value written to each destination word, no reads
        cfg_wr(32'h0, 32'hDEAD_BEEF);
        cfg_wr(32'h4, 32'h40);
        cfg_wr(32'h8, 32'd2);
        x.wstrb = 4'hF; x.wdata = 32'hDEAD_BEEF;
        x.addr = 32'h40; exp_q.push_back(x);
        x.addr = 32'h44; exp_q.push_back(x);
        n_rd = 0; n_wr = 0;
        cfg_wr(32'hC, 32'h11);
        wait_idle(50);
        check32("fill_nrd", n_rd, 32'd0);
        check32("fill_nwr", n_wr, 32'd2);
        check32("fill_q", exp_q.size(), 32'd0);
        cfg_rd("fill_stat", 32'hC, 32'h14);
`else
        // Without fill support, CTRL bit4 reads back as 0
        cfg_wr(32'hC, 32'h10);
        cfg_rd("nofill_stat", 32'hC, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Word-copy DMA engine on the native picorv32 memory bus.
- Config side is a bus responder, decoded externally like other peripherals; the top drives cfg_valid = mem_valid && sel.
- Data side is a bus initiator that issues valid/addr/wstrb transactions and waits for ready.
- Copies LEN 32-bit words from SRC to DST and optionally raises an irq line when done.

Parameters:
- LEN_BITS, 16, width of the word-count register; max transfer is 2^LEN_BITS-1 words.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cfg_valid  input  1  config access request
- cfg_ready  output  1  config access complete, one-cycle pulse
- cfg_wstrb  input  4  byte strobes; 0 = read
- cfg_addr  input  32  only [3:2] used
- cfg_wdata  input  32  write data
- cfg_rdata  output  32  read data, valid while cfg_ready
- m_valid  output  1  initiator request
- m_ready  input  1  target completion
- m_addr  output  32  word address, [1:0]=0
- m_wdata  output  32  write data
- m_wstrb  output  4  4'hF write, 4'h0 read
- m_rdata  input  32  read data, sampled when m_valid && m_ready
- irq  output  1  level interrupt

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: all outputs 0; SRC=DST=LEN=0; state IDLE; done=0; irq_en=0.
- Config registers, by cfg_addr[3:2]:
  - 0 SRC: bits [1:0] read as 0.
  - 1 DST: bits [1:0] read as 0.
  - 2 LEN: LEN_BITS wide, zero-extended on read.
  - 3 CTRL/STAT:
    - bit0 START: write-1 pulse, reads 0.
    - bit1 BUSY: read-only.
    - bit2 DONE: write-1-clears.
    - bit3 IRQ_EN: read/write.
- Config handshake:
  - cfg_ready pulses for one cycle, the cycle after cfg_valid is sampled high while cfg_ready=0.
  - Writes are applied on that same edge.
  - cfg_rdata is 0 whenever cfg_ready=0.
  - Byte strobes apply per byte to SRC/DST/LEN. CTRL acts only on byte 0.
- Writes to SRC/DST/LEN while BUSY are ignored. A START write while BUSY is ignored.
- Working copies: on START the engine loads src_ptr=SRC, dst_ptr=DST, count=LEN. SRC/DST/LEN registers keep their programmed values.
- FSM states: IDLE, RD, WR.
  - IDLE: START with LEN!=0 sets BUSY, clears DONE, goes to RD. START with LEN=0 sets DONE directly, issues no bus cycles.
  - RD: m_valid=1, m_addr=src_ptr, m_wstrb=0. On m_ready, latch m_rdata into buf, src_ptr+=4, go to WR.
  - WR: m_valid=1, m_addr=dst_ptr, m_wdata=buf, m_wstrb=F. On m_ready, dst_ptr+=4, count-=1. If count was 1, go to IDLE, clear BUSY, set DONE; otherwise go to RD.
- m_valid drops the cycle after m_ready. m_addr, m_wdata and m_wstrb stay stable while m_valid=1 && !m_ready.
- Minimum of 2 clocks per bus access (request cycle plus the cycle after ready); a zero-wait target yields 4 clocks per word.
- Pointer arithmetic is modulo 2^32, so 0xFFFFFFFC+4 wraps to 0.
- irq = DONE && IRQ_EN, registered, one cycle after DONE sets.
- Simultaneous events:
  - DONE-clear write in the same cycle as completion: the completion wins, DONE stays 1.
  - START together with a DONE-clear write: START processed, DONE cleared.
- Reset mid-transfer: m_valid is 0 after the reset edge. No further bus access occurs; an in-flight target response is ignored.

Optional Feature:
- Macro: MEM_DMA_FILL_EN.
- Defined: CTRL bit4 FILL is read/write. START with FILL=1 skips RD entirely. Each WR writes the SRC register value (buf=SRC) to dst_ptr; src_ptr is unchanged; 2 clocks per word with a zero-wait target.
- Undefined: bit4 reads 0, writes ignored, no fill logic synthesized.

Test Plan:
- Copy: SRC=0x100, DST=0x200, LEN=3, IRQ_EN=1, START, zero-wait target with m_rdata=addr^0xA5A5A5A5 -> reads 0x100/0x104/0x108 and writes 0x200/0x204/0x208 with matching data and wstrb F, alternating; irq=1; total 12 clocks of bus activity.
- Wait states: target asserts m_ready 3 cycles after m_valid -> m_addr/m_wdata/m_wstrb stable throughout; exactly one transfer per request.
- LEN=0 START -> no m_valid; STAT reads 0x4 (0xC with IRQ_EN=1); write 0x4 to CTRL -> DONE=0, irq=0.
- Busy protection: during a LEN=4 transfer, write DST=0x999 and START -> DST reads old value; exactly 4 writes occur.
- Wrap and reset: SRC=0xFFFFFFFC, LEN=2 -> second read at 0x0. Assert reset during WR with m_ready low -> next cycle m_valid=0, STAT=0.
- FILL (macro defined): SRC=0xDEADBEEF, DST=0x40, LEN=2, FILL=1 -> no reads; writes 0xDEADBEEF to 0x40 and 0x44; DONE=1.
